// File: rtl/logic_op_arbiter.sv
// logic_op_arbiter: two requesters share one registered AND/OR/XOR unit.
// A round-robin arbiter accepts one request at a time. The request is latched,
// computed in EXEC, and returned on a single response channel that is tagged
// with the requester ID.
//
// Ports:
//   clk, reset            clock and asynchronous active-high reset
//   reqN_valid/ready      request handshake (N = 0, 1); ready is combinational
//   reqN_a, reqN_b        operands
//   reqN_op               opcode (0 AND, 1 OR, 2 XOR, others are errors)
//   rsp_valid/ready       response handshake
//   rsp_id                owner of the response
//   rsp_data, rsp_err     result and unsupported-opcode flag
module logic_op_arbiter #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [DATA_WIDTH-1:0]    req0_a,
  input  logic [DATA_WIDTH-1:0]    req0_b,
  input  logic [OPCODE_LENGTH-1:0] req0_op,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [DATA_WIDTH-1:0]    req1_a,
  input  logic [DATA_WIDTH-1:0]    req1_b,
  input  logic [OPCODE_LENGTH-1:0] req1_op,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_id,
  output logic [DATA_WIDTH-1:0]    rsp_data,
  output logic                     rsp_err
);

  localparam logic [OPCODE_LENGTH-1:0] OpAnd = OPCODE_LENGTH'(0);
  localparam logic [OPCODE_LENGTH-1:0] OpOr  = OPCODE_LENGTH'(1);
  localparam logic [OPCODE_LENGTH-1:0] OpXor = OPCODE_LENGTH'(2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } stateT;

  stateT                    state;
  stateT                    stateNext;
  logic                     grant0;
  logic                     grant1;
  logic                     lastGrant;
  logic [DATA_WIDTH-1:0]    latA;
  logic [DATA_WIDTH-1:0]    latB;
  logic [OPCODE_LENGTH-1:0] latOp;
  logic                     latId;
  logic [DATA_WIDTH-1:0]    opResult;
  logic                     opErr;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next state and round-robin grant; a grant always implies acceptance
  // because it is only given to a valid requester.
  always_comb begin
    stateNext = state;
    grant0    = 1'b0;
    grant1    = 1'b0;
    case (state)
      IDLE: begin
        grant0 = req0_valid & (~req1_valid | lastGrant);
        grant1 = req1_valid & (~req0_valid | ~lastGrant);
        if (grant0 | grant1) begin
          stateNext = EXEC;
        end
      end
      EXEC: stateNext = RESP;
      RESP: begin
        if (rsp_ready) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Ready is forced low while reset is asserted so nothing looks accepted.
  assign req0_ready = grant0 & ~reset;
  assign req1_ready = grant1 & ~reset;

  // Logic unit working only on the latched operands
  always_comb begin
    opResult = '0;
    opErr    = 1'b0;
    case (latOp)
      OpAnd:   opResult = latA & latB;
      OpOr:    opResult = latA | latB;
      OpXor:   opResult = latA ^ latB;
      default: opErr    = 1'b1;
    endcase
  end

  // Request latch, grant history and registered response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lastGrant <= 1'b1;
      latA      <= '0;
      latB      <= '0;
      latOp     <= '0;
      latId     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (grant0 | grant1) begin
        latA      <= grant1 ? req1_a  : req0_a;
        latB      <= grant1 ? req1_b  : req0_b;
        latOp     <= grant1 ? req1_op : req0_op;
        latId     <= grant1;
        lastGrant <= grant1;
      end
      if (state == EXEC) begin
        rsp_valid <= 1'b1;
        rsp_data  <= opResult;
        rsp_err   <= opErr;
        rsp_id    <= latId;
      end else if ((state == RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Bench for logic_op_arbiter: a 32-bit main instance checked through a
// scoreboard, plus 8-bit and 1-bit instances for single-operation cases.
module tb_logic_op_arbiter;

  typedef struct packed {
    logic        id;
    logic [31:0] data;
    logic        err;
  } expT;

  logic clk;
  logic reset;

  // 32-bit instance
  logic        r0Valid, r0Ready, r1Valid, r1Ready;
  logic [31:0] r0A, r0B, r1A, r1B;
  logic [3:0]  r0Op, r1Op;
  logic        rspValid, rspReady, rspId, rspErr;
  logic [31:0] rspData;

  // 8-bit instance
  logic        s8V0, s8R0, s8V1, s8R1, s8RspV, s8RspR, s8RspId, s8RspErr;
  logic [7:0]  s8A0, s8B0, s8A1, s8B1, s8RspData;
  logic [3:0]  s8Op0, s8Op1;

  // 1-bit instance
  logic        t1V0, t1R0, t1V1, t1R1, t1RspV, t1RspR, t1RspId, t1RspErr;
  logic        t1A0, t1B0, t1A1, t1B1, t1RspData;
  logic [3:0]  t1Op0, t1Op1;

  expT sb[$];
  int  nTests;
  int  nFail;

  logic_op_arbiter #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(r0Valid), .req0_ready(r0Ready), .req0_a(r0A), .req0_b(r0B), .req0_op(r0Op),
    .req1_valid(r1Valid), .req1_ready(r1Ready), .req1_a(r1A), .req1_b(r1B), .req1_op(r1Op),
    .rsp_valid(rspValid), .rsp_ready(rspReady), .rsp_id(rspId), .rsp_data(rspData), .rsp_err(rspErr)
  );

  logic_op_arbiter #(.DATA_WIDTH(8), .OPCODE_LENGTH(4)) dut8 (
    .clk(clk), .reset(reset),
    .req0_valid(s8V0), .req0_ready(s8R0), .req0_a(s8A0), .req0_b(s8B0), .req0_op(s8Op0),
    .req1_valid(s8V1), .req1_ready(s8R1), .req1_a(s8A1), .req1_b(s8B1), .req1_op(s8Op1),
    .rsp_valid(s8RspV), .rsp_ready(s8RspR), .rsp_id(s8RspId), .rsp_data(s8RspData), .rsp_err(s8RspErr)
  );

  logic_op_arbiter #(.DATA_WIDTH(1), .OPCODE_LENGTH(4)) dut1 (
    .clk(clk), .reset(reset),
    .req0_valid(t1V0), .req0_ready(t1R0), .req0_a(t1A0), .req0_b(t1B0), .req0_op(t1Op0),
    .req1_valid(t1V1), .req1_ready(t1R1), .req1_a(t1A1), .req1_b(t1B1), .req1_op(t1Op1),
    .rsp_valid(t1RspV), .rsp_ready(t1RspR), .rsp_id(t1RspId), .rsp_data(t1RspData), .rsp_err(t1RspErr)
  );

  always #5 clk = ~clk;

  // Reference behaviour of the shared logic unit
  function automatic expT model(input logic id, input logic [31:0] a, input logic [31:0] b,
                                input logic [3:0] op);
    expT r;
    r.id  = id;
    r.err = 1'b0;
    case (op)
      4'd0:    r.data = a & b;
      4'd1:    r.data = a | b;
      4'd2:    r.data = a ^ b;
      default: begin r.data = '0; r.err = 1'b1; end
    endcase
    return r;
  endfunction

  task automatic test_reset();
    r0Valid = 1'b1;
    r1Valid = 1'b1;
    @(negedge clk);
    #1;
    nTests++;
    if ({r0Ready, r1Ready} !== 2'b00) begin
      nFail++; $display("FAIL reset_ready: got %b, required 00", {r0Ready, r1Ready});
    end
    nTests++;
    if ({rspValid, rspId, rspErr, rspData} !== 35'd0) begin
      nFail++; $display("FAIL reset_rsp: valid=%b id=%b err=%b data=%h, required all 0",
                        rspValid, rspId, rspErr, rspData);
    end
    r0Valid = 1'b0;
    r1Valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    nTests++;
    if (rspValid !== 1'b0) begin
      nFail++; $display("FAIL reset_release: rsp_valid=%b, required 0", rspValid);
    end
  endtask

  task automatic test_single_or();
    @(negedge clk);
    s8V0 = 1'b1; s8A0 = 8'h0A; s8B0 = 8'h05; s8Op0 = 4'd1; s8RspR = 1'b1;
    #1;
    nTests++;
    if (s8R0 !== 1'b1) begin
      nFail++; $display("FAIL or8_ready: got %b, required 1", s8R0);
    end
    @(posedge clk);
    #1;
    s8V0 = 1'b0;
    nTests++;
    if (s8RspV !== 1'b0) begin
      nFail++; $display("FAIL or8_latency_early: rsp_valid=%b after accept edge, required 0", s8RspV);
    end
    @(posedge clk);
    #1;
    nTests++;
    if ({s8RspV, s8RspId, s8RspErr, s8RspData} !== {1'b1, 1'b0, 1'b0, 8'h0F}) begin
      nFail++; $display("FAIL or8_rsp: valid=%b id=%b err=%b data=%h, required 1 0 0 0f",
                        s8RspV, s8RspId, s8RspErr, s8RspData);
    end
    @(posedge clk);
    #1;
    nTests++;
    if (s8RspV !== 1'b0) begin
      nFail++; $display("FAIL or8_handshake: rsp_valid=%b, required 0", s8RspV);
    end
  endtask

  task automatic test_one_bit();
    @(negedge clk);
    t1V0 = 1'b1; t1A0 = 1'b1; t1B0 = 1'b0; t1Op0 = 4'd1; t1RspR = 1'b1;
    #1;
    nTests++;
    if (t1R0 !== 1'b1) begin
      nFail++; $display("FAIL or1_ready: got %b, required 1", t1R0);
    end
    @(posedge clk);
    #1;
    t1V0 = 1'b0;
    @(posedge clk);
    #1;
    nTests++;
    if ({t1RspV, t1RspData, t1RspErr, t1RspId} !== 4'b1100) begin
      nFail++; $display("FAIL or1_rsp: valid=%b data=%b err=%b id=%b, required 1 1 0 0",
                        t1RspV, t1RspData, t1RspErr, t1RspId);
    end
  endtask

  task automatic test_contention();
    expT  e;
    logic prevGid;
    int   nGrant;
    int   nRsp;
    prevGid = 1'b1;
    nGrant  = 0;
    nRsp    = 0;
    @(negedge clk);
    r0Valid = 1'b1; r0A = 32'hFFFF0000; r0B = 32'h0F0F0F0F; r0Op = 4'd0;
    r1Valid = 1'b1; r1A = 32'hAAAAAAAA; r1B = 32'hFFFFFFFF; r1Op = 4'd2;
    rspReady = 1'b1;
    for (int c = 0; c < 15; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (r0Ready && r1Ready) begin
        nTests++; nFail++;
        $display("FAIL contention_both_ready: cycle %0d both readys high, required one", c);
      end else if (r0Ready || r1Ready) begin
        nTests++;
        if (r1Ready === prevGid) begin
          nFail++; $display("FAIL contention_alternate: grant %0d got id %b, required %b",
                            nGrant, r1Ready, ~prevGid);
        end
        prevGid = r1Ready;
        nGrant++;
        sb.push_back(r1Ready ? model(1'b1, r1A, r1B, r1Op) : model(1'b0, r0A, r0B, r0Op));
      end
      if (rspValid && rspReady) begin
        nTests++;
        nRsp++;
        if (sb.size() == 0) begin
          nFail++; $display("FAIL contention_rsp: unexpected id=%b data=%h, required none", rspId, rspData);
        end else begin
          e = sb.pop_front();
          if ({rspId, rspData, rspErr} !== {e.id, e.data, e.err}) begin
            nFail++; $display("FAIL contention_rsp: id=%b data=%h err=%b, required id=%b data=%h err=%b",
                              rspId, rspData, rspErr, e.id, e.data, e.err);
          end
        end
      end
    end
    r0Valid = 1'b0;
    r1Valid = 1'b0;
    nTests++;
    if (nRsp < 3 || sb.size() != 0) begin
      nFail++; $display("FAIL contention_count: responses=%0d pending=%0d, required >=3 and 0",
                        nRsp, sb.size());
    end
  endtask

  task automatic test_backpressure();
    expT  e;
    logic acc0, acc1;
    int   nGrant;
    @(negedge clk);
    r0Valid = 1'b0;
    r1Valid = 1'b1; r1A = 32'hC3C35A5A; r1B = 32'h0FF0F00F; r1Op = 4'd2;
    rspReady = 1'b0;
    #1;
    nTests++;
    if (r1Ready !== 1'b1) begin
      nFail++; $display("FAIL bp_accept: req1_ready=%b, required 1", r1Ready);
    end
    sb.push_back(model(1'b1, r1A, r1B, r1Op));
    @(negedge clk);
    r1A = $urandom; r1B = $urandom; r1Op = 4'd0;
    r0Valid = 1'b1; r0A = 32'h12345678; r0B = 32'h00FF00FF; r0Op = 4'd1;
    #1;
    nTests++;
    if ({r0Ready, r1Ready, rspValid} !== 3'b000) begin
      nFail++; $display("FAIL bp_exec: ready0/ready1/rsp_valid=%b, required 000", {r0Ready, r1Ready, rspValid});
    end
    e = sb[0];
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      r1A = $urandom; r1B = $urandom; r1Op = 4'($urandom_range(0, 2));
      #1;
      nTests++;
      if ({r0Ready, r1Ready} !== 2'b00) begin
        nFail++; $display("FAIL bp_ready: hold cycle %0d readys=%b, required 00", k, {r0Ready, r1Ready});
      end
      nTests++;
      if ({rspValid, rspId, rspData, rspErr} !== {1'b1, e.id, e.data, e.err}) begin
        nFail++; $display("FAIL bp_stable: hold cycle %0d valid=%b id=%b data=%h err=%b, required 1 %b %h %b",
                          k, rspValid, rspId, rspData, rspErr, e.id, e.data, e.err);
      end
    end
    @(negedge clk);
    rspReady = 1'b1;
    #1;
    nTests++;
    if (!rspValid) begin
      nFail++; $display("FAIL bp_release: rsp_valid=%b, required 1", rspValid);
    end else begin
      e = sb.pop_front();
      if ({rspId, rspData, rspErr} !== {e.id, e.data, e.err}) begin
        nFail++; $display("FAIL bp_release: id=%b data=%h err=%b, required id=%b data=%h err=%b",
                          rspId, rspData, rspErr, e.id, e.data, e.err);
      end
    end
    acc0 = 1'b0; acc1 = 1'b0; nGrant = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (acc0) r0Valid = 1'b0;
      if (acc1) r1Valid = 1'b0;
      acc0 = 1'b0; acc1 = 1'b0;
      #1;
      if (c == 0) begin
        nTests++;
        if (rspValid !== 1'b0) begin
          nFail++; $display("FAIL bp_single: rsp_valid=%b after handshake, required 0", rspValid);
        end
      end
      if (r0Ready) begin acc0 = 1'b1; nGrant++; sb.push_back(model(1'b0, r0A, r0B, r0Op)); end
      if (r1Ready) begin acc1 = 1'b1; nGrant++; sb.push_back(model(1'b1, r1A, r1B, r1Op)); end
      if (rspValid && rspReady) begin
        nTests++;
        if (sb.size() == 0) begin
          nFail++; $display("FAIL bp_drain: unexpected id=%b data=%h, required none", rspId, rspData);
        end else begin
          e = sb.pop_front();
          if ({rspId, rspData, rspErr} !== {e.id, e.data, e.err}) begin
            nFail++; $display("FAIL bp_drain: id=%b data=%h err=%b, required id=%b data=%h err=%b",
                              rspId, rspData, rspErr, e.id, e.data, e.err);
          end
        end
      end
    end
    nTests++;
    if (nGrant != 2 || sb.size() != 0) begin
      nFail++; $display("FAIL bp_done: grants=%0d pending=%0d, required 2 and 0", nGrant, sb.size());
    end
  endtask

  task automatic test_bad_opcode();
    expT  e;
    logic acc;
    logic got;
    acc = 1'b0;
    got = 1'b0;
    @(negedge clk);
    r0Valid = 1'b0;
    r1Valid = 1'b1; r1A = 32'h00001234; r1B = 32'h0000FFFF; r1Op = 4'd7;
    rspReady = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      if (acc) r1Valid = 1'b0;
      #1;
      acc = 1'b0;
      if (r1Ready) begin
        acc = 1'b1;
        e.id = 1'b1; e.data = 32'h0; e.err = 1'b1;
        sb.push_back(e);
      end
      if (rspValid && rspReady) begin
        nTests++;
        got = 1'b1;
        if (sb.size() == 0) begin
          nFail++; $display("FAIL badop_rsp: unexpected id=%b data=%h, required none", rspId, rspData);
        end else begin
          e = sb.pop_front();
          if ({rspId, rspData, rspErr} !== {e.id, e.data, e.err}) begin
            nFail++; $display("FAIL badop_rsp: id=%b data=%h err=%b, required id=%b data=%h err=%b",
                              rspId, rspData, rspErr, e.id, e.data, e.err);
          end
        end
      end
    end
    r1Valid = 1'b0;
    nTests++;
    if (!got || sb.size() != 0) begin
      nFail++; $display("FAIL badop_timeout: response seen=%b pending=%0d, required 1 and 0", got, sb.size());
    end
  endtask

  task automatic test_reset_mid_op();
    expT  e;
    logic acc0, acc1;
    int   nRsp;
    // Reset while EXEC: no response may ever appear
    @(negedge clk);
    r0Valid = 1'b1; r1Valid = 1'b0; r0A = 32'h0000F0F0; r0B = 32'h00000F0F; r0Op = 4'd1;
    rspReady = 1'b1;
    #1;
    nTests++;
    if (r0Ready !== 1'b1) begin
      nFail++; $display("FAIL rst_exec_accept: req0_ready=%b, required 1", r0Ready);
    end
    @(negedge clk);
    r0Valid = 1'b0;
    reset = 1'b1;
    #1;
    nTests++;
    if ({rspValid, r0Ready, r1Ready} !== 3'b000) begin
      nFail++; $display("FAIL rst_exec_now: valid/ready0/ready1=%b, required 000", {rspValid, r0Ready, r1Ready});
    end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      nTests++;
      if (rspValid !== 1'b0) begin
        nFail++; $display("FAIL rst_exec_stale: cycle %0d rsp_valid=%b, required 0", c, rspValid);
      end
    end
    // Reset while RESP: outputs clear without a clock edge
    r1Valid = 1'b1; r1A = 32'h00FF00FF; r1B = 32'hFF000000; r1Op = 4'd1;
    rspReady = 1'b0;
    @(negedge clk);
    r1Valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    nTests++;
    if ({rspValid, rspId, rspData} !== {1'b1, 1'b1, 32'hFFFF00FF}) begin
      nFail++; $display("FAIL rst_resp_pre: valid=%b id=%b data=%h, required 1 1 ffff00ff",
                        rspValid, rspId, rspData);
    end
    #1;
    reset = 1'b1;
    #1;
    nTests++;
    if ({rspValid, rspId, rspErr, rspData} !== 35'd0) begin
      nFail++; $display("FAIL rst_resp_now: valid=%b id=%b err=%b data=%h, required all 0",
                        rspValid, rspId, rspErr, rspData);
    end
    @(negedge clk);
    reset = 1'b0;
    rspReady = 1'b1;
    r0Valid = 1'b1; r0A = 32'h80000001; r0B = 32'h00000003; r0Op = 4'd2;
    r1Valid = 1'b1; r1A = 32'h0000FFFF; r1B = 32'h00FF00FF; r1Op = 4'd0;
    #1;
    nTests++;
    if ({r0Ready, r1Ready} !== 2'b10) begin
      nFail++; $display("FAIL rst_first_grant: ready0/ready1=%b, required 10", {r0Ready, r1Ready});
    end
    acc0 = 1'b0; acc1 = 1'b0; nRsp = 0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) begin
        @(negedge clk);
        if (acc0) r0Valid = 1'b0;
        if (acc1) r1Valid = 1'b0;
        acc0 = 1'b0; acc1 = 1'b0;
        #1;
      end
      if (r0Ready) begin acc0 = 1'b1; sb.push_back(model(1'b0, r0A, r0B, r0Op)); end
      if (r1Ready) begin acc1 = 1'b1; sb.push_back(model(1'b1, r1A, r1B, r1Op)); end
      if (rspValid && rspReady) begin
        nTests++;
        nRsp++;
        if (sb.size() == 0) begin
          nFail++; $display("FAIL rst_after_rsp: unexpected id=%b data=%h, required none", rspId, rspData);
        end else begin
          e = sb.pop_front();
          if ({rspId, rspData, rspErr} !== {e.id, e.data, e.err}) begin
            nFail++; $display("FAIL rst_after_rsp: id=%b data=%h err=%b, required id=%b data=%h err=%b",
                              rspId, rspData, rspErr, e.id, e.data, e.err);
          end
        end
      end
    end
    nTests++;
    if (nRsp != 2 || sb.size() != 0) begin
      nFail++; $display("FAIL rst_after_count: responses=%0d pending=%0d, required 2 and 0", nRsp, sb.size());
    end
  endtask

  initial begin
    clk = 1'b0; reset = 1'b1;
    nTests = 0; nFail = 0;
    r0Valid = 1'b0; r0A = '0; r0B = '0; r0Op = '0;
    r1Valid = 1'b0; r1A = '0; r1B = '0; r1Op = '0;
    rspReady = 1'b0;
    s8V0 = 1'b0; s8A0 = '0; s8B0 = '0; s8Op0 = '0;
    s8V1 = 1'b0; s8A1 = '0; s8B1 = '0; s8Op1 = '0; s8RspR = 1'b0;
    t1V0 = 1'b0; t1A0 = 1'b0; t1B0 = 1'b0; t1Op0 = '0;
    t1V1 = 1'b0; t1A1 = 1'b0; t1B1 = 1'b0; t1Op1 = '0; t1RspR = 1'b0;

    test_reset();
    test_single_or();
    test_one_bit();
    test_contention();
    test_backpressure();
    test_bad_opcode();
    test_reset_mid_op();

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
